stretch_period_meter: RTL

Measures a slow square wave, such as a stretched clock, in units of the fast system clock.
- Synchronises the asynchronous input and times its high and low phases.
- Reports per-cycle measurements and a lock flag once the waveform repeatedly matches an expected half-period.
- Flags loss of signal with a timeout.
- Used to self-check clock dividers/stretchers and to measure externally supplied slow clocks.

---
 rtl/stretch_period_meter.sv | 99 +++++++++
 1 files changed

// File: rtl/stretch_period_meter.sv
// stretch_period_meter: times high/low phases of a slow asynchronous square wave in system clocks,
// publishes each full period, and tracks lock against an expected half-period plus loss-of-signal timeout.
module stretch_period_meter #(
    parameter logic [31:0] EXPECTED_HALF = 32'd100000000,
    parameter logic [31:0] TOLERANCE     = 32'd1000,
    parameter int unsigned LOCK_COUNT    = 4,
    parameter logic [31:0] TIMEOUT       = 32'd250000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        signal_in,
    output logic [31:0] high_cycles,
    output logic [31:0] low_cycles,
    output logic [32:0] period_cycles,
    output logic        sample_valid,
    output logic        locked,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [32:0] HI_B = {1'b0, EXPECTED_HALF} + {1'b0, TOLERANCE};
    localparam logic [32:0] LO_B = (EXPECTED_HALF >= TOLERANCE) ? {1'b0, EXPECTED_HALF - TOLERANCE} : 33'd0;
    localparam logic [7:0]  LOCK_MAX = 8'(LOCK_COUNT);

    state_t      state;
    logic        sync1, sync2, prev, have_high;
    logic [31:0] count, cap;
    logic [7:0]  match_cnt;
    logic        rise, fall, edge_seen;

    function automatic logic in_range(input logic [31:0] v);
        return ({1'b0, v} >= LO_B) && ({1'b0, v} <= HI_B);
    endfunction

    assign rise      = sync2 & ~prev;
    assign fall      = ~sync2 & prev;
    assign edge_seen = rise | fall;
    // capture saturates with the counter so a huge phase never reads back as zero
    assign cap       = (&count) ? count : count + 32'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            prev          <= 1'b0;
            count         <= '0;
            match_cnt     <= '0;
            have_high     <= 1'b0;
            state         <= IDLE;
            high_cycles   <= '0;
            low_cycles    <= '0;
            period_cycles <= '0;
            sample_valid  <= 1'b0;
            locked        <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            sync1        <= signal_in;
            sync2        <= sync1;
            prev         <= sync2;
            sample_valid <= 1'b0;
            count        <= edge_seen ? '0 : cap;
            if (sample_valid) begin
                if (in_range(high_cycles) && in_range(low_cycles)) begin
                    match_cnt <= (match_cnt >= LOCK_MAX) ? LOCK_MAX : match_cnt + 8'd1;
                    locked    <= (match_cnt >= LOCK_MAX - 8'd1);
                end else begin
                    match_cnt <= '0;
                    locked    <= 1'b0;
                end
            end
            if (edge_seen) begin
                timeout <= 1'b0;
                case (state)
                    IDLE: state <= rise ? HIGH : LOW;
                    HIGH: if (fall) begin
                        high_cycles <= cap;
                        have_high   <= 1'b1;
                        state       <= LOW;
                    end
                    LOW: if (rise) begin
                        low_cycles <= cap;
                        state      <= HIGH;
                        if (have_high) begin
                            period_cycles <= {1'b0, high_cycles} + {1'b0, cap};
                            sample_valid  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (count == TIMEOUT - 32'd1) begin
                timeout   <= 1'b1;
                locked    <= 1'b0;
                match_cnt <= '0;
                have_high <= 1'b0;
                state     <= IDLE;
            end
        end
    end
endmodule
